seq_hit_logger: RTL and testbench
=================================

# seq_hit_logger

Downstream stage of the serial sequence detector. Consumes the detector's one-cycle detection pulse and timestamps each hit against a free-running cycle counter. Buffers hit records in a small FIFO and presents them to a host-side consumer over a valid/ready handshake. Also keeps a saturating hit total and a sticky overflow flag for status readout.

## Interface
Parameters:
- TS_W, 16, timestamp width; timestamp counter wraps modulo 2^TS_W
- SEQ_W, 8, width of per-event sequence number and of hit total
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- hit_in  in  1  detection pulse from detector output; each high cycle is one hit
- clr  in  1  synchronous clear of all state except clk domain reset logic
- evt_valid  out  1  head record available
- evt_ready  in  1  consumer accepts head record
- evt_ts  out  TS_W  timestamp of head record
- evt_seq  out  SEQ_W  sequence number of head record
- hit_total  out  SEQ_W  saturating count of hits seen since reset/clr
- overflow  out  1  sticky: at least one hit dropped
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- ts counter: reset 0, +1 every cycle, wraps at 2^TS_W-1 → 0.
- seq counter: reset 0; +1 on every hit_in=1 cycle, including dropped hits (gaps in evt_seq expose drops); wraps.
- hit_total: +1 per hit, saturates at 2^SEQ_W-1, never wraps.
- Push: on hit_in=1, record {ts, seq} with values current in that cycle (pre-increment).
- FIFO occupancy states: EMPTY (level 0), PARTIAL, FULL (level DEPTH).
  - EMPTY + hit → PARTIAL (or FULL if DEPTH reached).
  - FULL + hit + pop same cycle → push accepted, stays FULL, no overflow.
  - FULL + hit, no pop → hit dropped, overflow←1, seq and hit_total still advance.
  - EMPTY + evt_ready → no effect.
  - Simultaneous push and pop in PARTIAL → level unchanged.
- Pop: evt_valid && evt_ready at rising edge.
- evt_valid = (level != 0); evt_ts/evt_seq driven from head entry, held stable while evt_valid && !evt_ready.
- clr=1: FIFO emptied, ts, seq, hit_total, overflow → 0 on next edge; clr wins over hit_in and pop in same cycle (that hit is not recorded, not counted).
- Reset values: evt_valid 0, evt_ts 0, evt_seq 0, hit_total 0, overflow 0, level 0.

## Timing
- Push latency: hit_in high in cycle N → evt_valid high in cycle N+1 (FIFO empty case).
- Pop takes effect at the accepting edge; next head visible the following cycle, no bubble: back-to-back pops at full throughput.
- level, hit_total, overflow update at the same edge as the push/pop causing them.
- hit_in assumed synchronous to clk (detector output is registered); no synchronizer.
- Consecutive-cycle hits are each recorded; throughput 1 hit/cycle.
- rst_n asserted mid-operation: all state cleared asynchronously; outputs at reset values immediately; pending records lost.

## Structure
- Package seq_log_pkg: event record typedef {ts, seq}, default TS_W/SEQ_W constants, level-width function.
- Sub-module seq_log_fifo: generic synchronous FIFO (DEPTH entries, push/pop, full/empty, level, pointer wrap using extra MSB). Top holds ts/seq/total counters, drop logic, clr priority.

## Test plan
- Reset then single hit at ts=5 → cycle 6 evt_valid=1, evt_ts=5, evt_seq=0, hit_total=1; pop with ready → evt_valid=0, level=0.
- 5 hits in consecutive cycles, ready=0, DEPTH=4 → level=4, overflow=1, hit_total=5; drain gives seq 0,1,2,3 with ts incrementing by 1.
- FIFO full, hit with evt_ready=1 same cycle → overflow stays 0, level stays 4, new tail seq=4.
- 300 hits with ready=1, SEQ_W=8 → hit_total=255 saturated, evt_seq wraps 255→0.
- ts wrap: TS_W=4, hit at cycle 17 → evt_ts=1.
- clr asserted with simultaneous hit and pending 2 records → next cycle level=0, hit_total=0, overflow=0, no record; rst_n pulse mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/seq_log_pkg.sv
// rtl/seq_log_pkg.sv - shared types, default widths and level-width helper for the hit logger
package seq_log_pkg;

  localparam int DEF_TS_W  = 16;
  localparam int DEF_SEQ_W = 8;
  localparam int DEF_DEPTH = 4;

  // One logged hit at default widths: when it happened and its running sequence number
  typedef struct packed {
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_SEQ_W-1:0] seq;
  } evt_rec_t;

  // Occupancy needs one extra bit so that a full FIFO (level == depth) is representable
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/seq_log_fifo.sv
// rtl/seq_log_fifo.sv - synchronous FIFO with extra-MSB pointers and a clear that beats push/pop
module seq_log_fifo
  import seq_log_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  // Pointers differ only in the MSB when the FIFO has wrapped all the way round
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero when nothing is stored so stale entries never leak out
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers: clear collapses both to zero regardless of push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the empty-gated read keeps the output clean instead
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/seq_hit_logger.sv
// rtl/seq_hit_logger.sv - timestamps detector hits, buffers them and tracks totals and drops
module seq_hit_logger
  import seq_log_pkg::*;
#(
  parameter int TS_W  = DEF_TS_W,
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hit_in,
  input  logic                       clr,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_ts,
  output logic [SEQ_W-1:0]           evt_seq,
  output logic [SEQ_W-1:0]           hit_total,
  output logic                       overflow,
  output logic [level_w(DEPTH)-1:0]  level
);

  logic [TS_W-1:0]       ts_q, ts_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [SEQ_W-1:0]      total_q, total_d;
  logic                  ovf_q, ovf_d;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;
  logic [TS_W+SEQ_W-1:0] head;

  // Handshake pop; a hit is lost only when full and the head is not leaving
  assign pop  = evt_ready && !fifo_empty;
  assign drop = hit_in && fifo_full && !pop;

  seq_log_fifo #(
    .WIDTH (TS_W + SEQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (hit_in),
    .pop   (pop),
    .wdata ({ts_q, seq_q}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign evt_valid          = !fifo_empty;
  assign {evt_ts, evt_seq}  = head;
  assign hit_total          = total_q;
  assign overflow           = ovf_q;

  // Counter updates: seq advances on every hit (dropped ones too), total saturates, clr wins
  always_comb begin
    ts_d    = ts_q + 1'b1;
    seq_d   = seq_q;
    total_d = total_q;
    ovf_d   = ovf_q | drop;
    if (hit_in) begin
      seq_d = seq_q + 1'b1;
      if (total_q != '1) total_d = total_q + 1'b1;
    end
    if (clr) begin
      ts_d    = '0;
      seq_d   = '0;
      total_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // Counter and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      seq_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      seq_q   <= seq_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seq_hit_logger.sv
// tb/tb_seq_hit_logger.sv - self-checking bench for seq_hit_logger
module tb_seq_hit_logger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hit_in = 1'b0;
  logic        clr = 1'b0;
  logic        evt_ready = 1'b0;

  logic        evt_valid;
  logic [15:0] evt_ts;
  logic [7:0]  evt_seq;
  logic [7:0]  hit_total;
  logic        overflow;
  logic [2:0]  level;

  logic        v4;
  logic [3:0]  ts4;
  logic [7:0]  seq4;
  logic [7:0]  tot4;
  logic        ovf4;
  logic [2:0]  lvl4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of logged records plus plain integer counters
  int mq_ts[$];
  int mq_seq[$];
  int m_ts, m_seq, m_tot, m_ovf;

  typedef struct {
    bit hit, rdy, clr;
    bit v;
    int lvl, tot;
    bit ovf;
    int ts, seq;
  } vec_t;
  vec_t vecs[$];

  seq_hit_logger u_dut (
    .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_seq(evt_seq),
    .hit_total(hit_total), .overflow(overflow), .level(level)
  );

  seq_hit_logger #(.TS_W(4), .SEQ_W(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .clr(clr),
    .evt_valid(v4), .evt_ready(evt_ready), .evt_ts(ts4), .evt_seq(seq4),
    .hit_total(tot4), .overflow(ovf4), .level(lvl4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq_ts.delete();
    mq_seq.delete();
    m_ts = 0; m_seq = 0; m_tot = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    if (clr) begin
      model_reset();
    end else begin
      if (mq_ts.size() > 0 && evt_ready) begin
        void'(mq_ts.pop_front());
        void'(mq_seq.pop_front());
      end
      if (hit_in) begin
        if (mq_ts.size() < 4) begin
          mq_ts.push_back(m_ts);
          mq_seq.push_back(m_seq);
        end else begin
          m_ovf = 1;
        end
        m_seq = (m_seq + 1) % 256;
        if (m_tot < 255) m_tot++;
      end
      m_ts = (m_ts + 1) % 65536;
    end
  endtask

  task automatic check_model();
    int n;
    n = mq_ts.size();
    chk("valid", evt_valid, n != 0);
    chk("level", level, n);
    chk("hit_total", hit_total, m_tot);
    chk("overflow", overflow, m_ovf);
    chk("valid4", v4, n != 0);
    chk("level4", lvl4, n);
    chk("hit_total4", tot4, m_tot);
    chk("overflow4", ovf4, m_ovf);
    if (n != 0) begin
      chk("evt_ts", evt_ts, mq_ts[0]);
      chk("evt_seq", evt_seq, mq_seq[0]);
      chk("evt_ts4", ts4, mq_ts[0] % 16);
      chk("evt_seq4", seq4, mq_seq[0]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit h, input bit r, input bit c);
    hit_in = h; evt_ready = r; clr = c;
  endtask

  task automatic addv(input bit h, input bit r, input bit c, input bit v,
                      input int lvl, input int tot, input bit ovf, input int ts, input int seq);
    vec_t e;
    e.hit = h; e.rdy = r; e.clr = c; e.v = v;
    e.lvl = lvl; e.tot = tot; e.ovf = ovf; e.ts = ts; e.seq = seq;
    vecs.push_back(e);
  endtask

  initial begin
    bit saw_wrap;
    int prev_seq;

    // Vector table: one row per cycle from reset release (first row sees ts=0)
    for (int i = 0; i < 5; i++) addv(0,0,0, 0,0,0,0, 0,0);
    addv(1,0,0, 1,1,1,0, 5,0);
    addv(0,1,0, 0,0,1,0, 0,0);
    addv(0,0,1, 0,0,0,0, 0,0);
    addv(1,0,0, 1,1,1,0, 0,0);
    addv(1,0,0, 1,2,2,0, 0,0);
    addv(1,0,0, 1,3,3,0, 0,0);
    addv(1,0,0, 1,4,4,0, 0,0);
    addv(1,0,0, 1,4,5,1, 0,0);
    addv(0,1,0, 1,3,5,1, 1,1);
    addv(0,1,0, 1,2,5,1, 2,2);
    addv(0,1,0, 1,1,5,1, 3,3);
    addv(0,1,0, 0,0,5,1, 0,0);
    addv(0,0,1, 0,0,0,0, 0,0);
    addv(1,0,0, 1,1,1,0, 0,0);
    addv(1,0,0, 1,2,2,0, 0,0);
    addv(1,0,0, 1,3,3,0, 0,0);
    addv(1,0,0, 1,4,4,0, 0,0);
    addv(1,1,0, 1,4,5,0, 1,1);
    addv(0,1,0, 1,3,5,0, 2,2);
    addv(0,1,0, 1,2,5,0, 3,3);
    addv(0,1,0, 1,1,5,0, 4,4);
    addv(0,1,0, 0,0,5,0, 0,0);
    addv(1,0,0, 1,1,6,0, 9,5);
    addv(1,0,0, 1,2,7,0, 9,5);
    addv(1,1,1, 0,0,0,0, 0,0);
    addv(0,0,0, 0,0,0,0, 0,0);

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_seq", evt_seq, 0);
    chk("rst_total", hit_total, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].hit, vecs[i].rdy, vecs[i].clr);
      cycle();
      chk($sformatf("vec%0d_valid", i), evt_valid, vecs[i].v);
      chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
      chk($sformatf("vec%0d_total", i), hit_total, vecs[i].tot);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_ts", i), evt_ts, vecs[i].ts);
        chk($sformatf("vec%0d_seq", i), evt_seq, vecs[i].seq);
      end
    end

    // Timestamp wrap on the 4-bit instance: hit at cycle 17 reads back as 1
    drive(0,0,1); cycle();
    drive(0,0,0);
    repeat (17) cycle();
    drive(1,0,0); cycle();
    check_model();
    chk("wrap_ts16", evt_ts, 17);
    chk("wrap_ts4", ts4, 1);
    drive(0,1,0); cycle();
    check_model();

    // 300 back-to-back hits drained at full rate: total saturates, seq wraps
    drive(0,0,1); cycle();
    saw_wrap = 0;
    prev_seq = -1;
    drive(1,1,0);
    for (int i = 0; i < 300; i++) begin
      cycle();
      check_model();
      if (prev_seq == 255 && evt_valid && evt_seq == 0) saw_wrap = 1;
      if (evt_valid) prev_seq = evt_seq;
    end
    chk("sat_total", hit_total, 255);
    chk("seq_wrap_seen", saw_wrap, 1);
    drive(0,1,0); cycle();
    check_model();

    // Asynchronous reset in the middle of a drain
    drive(1,0,0);
    repeat (3) begin cycle(); check_model(); end
    drive(0,1,0); cycle(); check_model();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", evt_valid, 0);
    chk("arst_ts", evt_ts, 0);
    chk("arst_seq", evt_seq, 0);
    chk("arst_total", hit_total, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_level", level, 0);
    model_reset();
    drive(0,0,0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
            $urandom_range(0, 199) == 0);
      cycle();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
